ntt_bfly_core: RTL and testbench
================================

// Module: ntt_bfly_core
// PURPOSE
//   Kyber NTT datapath core: dual-port polynomial RAM plus a pipelined Cooley-Tukey
//   butterfly (Montgomery multiply fqmul, then add/sub). Each issued op reads
//   f=RAM[lo] and a=RAM[hi], computes t=fqmul(a,zeta), and writes RAM[hi]=f-t and
//   RAM[lo]=f+t. An external sequencer supplies addresses/zetas; a host port loads and
//   reads coefficients while the pipeline is idle.
// PARAMETERS
//   N_ITEMS  256    RAM depth (coefficients)
//   ADDR_W   8      address width, clog2(N_ITEMS)
//   Q        3329   Kyber modulus
//   QINV     -3327  Q^-1 mod 2^16, signed 16-bit
// PORTS
//   clk          in   1   clock, all logic on rising edge
//   reset        in   1   synchronous, active-high
//   bf_valid     in   1   issue one butterfly this cycle
//   bf_addr_lo   in   8   address j (f operand, receives f+t)
//   bf_addr_hi   in   8   address j+len (a operand, receives f-t)
//   bf_zeta      in   16  signed twiddle, Montgomery domain
//   wb_valid     out  1   high the cycle before the op's RAM write edge
//   busy         out  1   any pipeline stage holds a valid op
//   host_we      in   1   host write strobe
//   host_re      in   1   host read strobe
//   host_addr    in   8   host address
//   host_wdata   in   16  host write data
//   host_rdata   out  16  host read data
//   host_rvalid  out  1   host_rdata valid (1 cycle after host_re)
// BEHAVIOUR
//   - One clock, reset synchronous active-high. Reset: all stage valids, wb_valid,
//     busy, host_rvalid = 0, host_rdata = 0. RAM contents retained (undefined at
//     power-up). Reset mid-op drops all in-flight ops; no RAM write after reset edge.
//   - Pipeline, issue sampled at edge E0, one op/cycle, no stalls:
//     E0: sync reads of lo and hi launched; zeta, addrs registered.
//     E1: prod <= signed(a)*signed(zeta), 32-bit; f registered.
//     E2: t <= mont(prod).
//     E3: r1 <= f - t, r2 <= f + t (16-bit two's-complement wrap); wb_valid <= 1.
//     E4: RAM[hi] <= r1 and RAM[lo] <= r2, same edge.
//   - mont(p): u = signed16(p[15:0]*QINV); t = (p - u*Q) >>> 16, low 16 bits.
//     Equals p*2^-16 mod Q, |t| < Q when |p| < Q*2^15.
//   - No forwarding. An op reading an address written by an op issued 1-4 cycles
//     earlier gets stale data; the sequencer must avoid this. Read and write of the
//     same address on one edge returns old data.
//   - hi == lo in one op is illegal; result undefined.
//   - busy = OR of valids for ops issued at E0..E3 not yet written (low after E4).
//   - Host: accepted only when busy=0 and bf_valid=0, otherwise silently dropped.
//     host_we writes host_wdata at that edge. host_re gives host_rdata and
//     host_rvalid=1 next cycle. host_we and host_re together: write wins, read dropped.
//   - bf_valid with busy=1 is legal (back-to-back pipelining).
// TESTING
//   1. Load RAM[0]=5, RAM[128]=100; issue lo=0, hi=128, zeta=2285 (R mod Q)
//      -> t=100, wb_valid 4 edges later; read back RAM[128]=0xFFA1 (-95), RAM[0]=0x0069.
//   2. zeta=0, RAM[lo]=0x0123 -> both lo and hi read back 0x0123.
//   3. RAM[lo]=0x7FFF, RAM[hi]=1, zeta=2285 -> lo=0x8000 (wrap), hi=0x7FFE.
//   4. 128 back-to-back ops (j, j+128), zeta=2285, random in-range data -> one result
//      per cycle, all match C ntt() first-layer model; busy low 4 cycles after last issue.
//   5. Assert reset 2 cycles after an issue -> no RAM change, wb_valid/busy 0 next cycle.
//   6. host_we while busy=1 -> write dropped; host_re at idle -> data 1 cycle later.

Source files
------------

// File: rtl/ntt_bfly_core.sv
// Kyber NTT datapath core: coefficient RAM plus a four-stage Cooley-Tukey
// butterfly (Montgomery fqmul, then add/sub), with a host load/readback port.
module ntt_bfly_core #(
  parameter int N_ITEMS = 256,
  parameter int ADDR_W  = 8,
  parameter int Q       = 3329,
  parameter int QINV    = -3327
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bf_valid,
  input  logic [ADDR_W-1:0] bf_addr_lo,
  input  logic [ADDR_W-1:0] bf_addr_hi,
  input  logic [15:0]       bf_zeta,
  output logic              wb_valid,
  output logic              busy,
  input  logic              host_we,
  input  logic              host_re,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  output logic [15:0]       host_rdata,
  output logic              host_rvalid
);

  localparam logic [15:0]        QINV16 = 16'(QINV);
  localparam logic signed [31:0] Q32    = 32'(Q);

  logic [15:0] ram [N_ITEMS];

  // Stage valids; wb_valid doubles as the stage-3 valid.
  logic v0, v1, v2;

  logic [ADDR_W-1:0] lo0, hi0, lo1, hi1, lo2, hi2, lo3, hi3;
  logic [15:0]       zeta0, rd_lo, rd_hi;
  logic signed [15:0] f1, f2, t2, r1, r2;
  logic signed [31:0] prod1;

  logic               host_ok, host_wr, host_rd;
  logic signed [31:0] a_ext, z_ext;
  logic [15:0]        mont_u_raw;
  logic signed [31:0] mont_u_ext, mont_diff;

  assign busy    = v0 | v1 | v2 | wb_valid;
  // Host traffic only while the butterfly pipeline is fully idle; a write beats a read.
  assign host_ok = !busy && !bf_valid;
  assign host_wr = host_ok && host_we;
  assign host_rd = host_ok && host_re && !host_we;

  // NOTE: every always_comb output is assigned unconditionally on every pass,
  // so no storage (latch) can be inferred here.
  always_comb begin
    a_ext      = {{16{rd_hi[15]}}, rd_hi};
    z_ext      = {{16{zeta0[15]}}, zeta0};
    // u = signed16(p * QINV): only the low 16 bits of the product matter.
    mont_u_raw = prod1[15:0] * QINV16;
    mont_u_ext = {{16{mont_u_raw[15]}}, mont_u_raw};
    // Low half of (p - u*Q) is zero by construction; the upper half is p*2^-16 mod Q.
    mont_diff  = prod1 - mont_u_ext * Q32;
  end

  // NOTE: sequential state uses non-blocking assignments so every register in
  // the pipeline samples the pre-edge value of its predecessor.
  always_ff @(posedge clk) begin
    if (reset) begin
      v0          <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      wb_valid    <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      v0          <= bf_valid;
      v1          <= v0;
      v2          <= v1;
      wb_valid    <= v2;
      host_rvalid <= host_rd;
      if (host_rd) begin
        host_rdata <= ram[host_addr];
      end
    end
  end

  // Datapath registers carry no reset: their contents are qualified by the valids.
  always_ff @(posedge clk) begin
    lo0   <= bf_addr_lo;
    hi0   <= bf_addr_hi;
    zeta0 <= bf_zeta;

    lo1   <= lo0;
    hi1   <= hi0;
    f1    <= rd_lo;
    prod1 <= a_ext * z_ext;

    lo2   <= lo1;
    hi2   <= hi1;
    f2    <= f1;
    t2    <= 16'(mont_diff >>> 16);

    lo3   <= lo2;
    hi3   <= hi2;
    r1    <= f2 - t2;
    r2    <= f2 + t2;
  end

  // NOTE: the coefficient RAM is deliberately not reset; only its writes are
  // suppressed on a reset edge so in-flight ops never land.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wb_valid) begin
        ram[hi3] <= r1;
        ram[lo3] <= r2;
      end else if (host_wr) begin
        ram[host_addr] <= host_wdata;
      end
    end
    if (bf_valid) begin
      rd_lo <= ram[bf_addr_lo];
      rd_hi <= ram[bf_addr_hi];
    end
  end

endmodule

// File: tb/tb_ntt_bfly_core.sv
// Directed bench for ntt_bfly_core: butterfly results, pipeline timing,
// reset abort and host-port gating.
module tb_ntt_bfly_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        bf_valid;
  logic [7:0]  bf_addr_lo, bf_addr_hi;
  logic [15:0] bf_zeta;
  logic        wb_valid, busy;
  logic        host_we, host_re;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        host_rvalid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] model [256];
  logic [15:0] expv  [256];
  logic [15:0] rd;
  logic        rv;
  logic [15:0] tq;
  int          wb_count, wb_first;

  always #5 clk = ~clk;

  ntt_bfly_core dut (
    .clk        (clk),
    .reset      (reset),
    .bf_valid   (bf_valid),
    .bf_addr_lo (bf_addr_lo),
    .bf_addr_hi (bf_addr_hi),
    .bf_zeta    (bf_zeta),
    .wb_valid   (wb_valid),
    .busy       (busy),
    .host_we    (host_we),
    .host_re    (host_re),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_rvalid(host_rvalid)
  );

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference Kyber fqmul: montgomery_reduce(a*b), as in the C reference code.
  function automatic logic [15:0] fqmul(input logic [15:0] a, input logic [15:0] b);
    int      p;
    shortint u;
    int      t;
    p = int'(signed'(a)) * int'(signed'(b));
    u = shortint'(p * -3327);
    t = (p - int'(u) * 3329) >>> 16;
    return t[15:0];
  endfunction

  task automatic host_write(input logic [7:0] a, input logic [15:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    @(negedge clk);
    host_we    = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [15:0] d, output logic v);
    host_re   = 1'b1;
    host_addr = a;
    @(negedge clk);
    host_re   = 1'b0;
    d = host_rdata;
    v = host_rvalid;
  endtask

  task automatic issue(input logic [7:0] lo, input logic [7:0] hi, input logic [15:0] z);
    bf_valid   = 1'b1;
    bf_addr_lo = lo;
    bf_addr_hi = hi;
    bf_zeta    = z;
    @(negedge clk);
    bf_valid   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] d;
    logic        v;
    host_read(a, d, v);
    check_bit({tag, "_rvalid"}, v, 1'b1);
    check16(tag, d, exp);
  endtask

  initial begin
    reset = 1'b1; bf_valid = 1'b0; bf_addr_lo = '0; bf_addr_hi = '0; bf_zeta = '0;
    host_we = 1'b0; host_re = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (2) @(negedge clk);
    check_bit("rst_wb_valid", wb_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_rvalid", host_rvalid, 1'b0);
    check16("rst_rdata", host_rdata, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    // Test 1: f=5, a=100, zeta = R mod Q -> t=100; lo=105, hi=-95, 4-edge latency.
    host_write(8'd0, 16'd5);
    host_write(8'd128, 16'd100);
    issue(8'd0, 8'd128, 16'd2285);
    check_bit("t1_busy_e0", busy, 1'b1);
    @(negedge clk);
    check_bit("t1_wb_e1", wb_valid, 1'b0);
    @(negedge clk);
    check_bit("t1_wb_e2", wb_valid, 1'b0);
    @(negedge clk);
    check_bit("t1_wb_e3", wb_valid, 1'b1);
    check_bit("t1_busy_e3", busy, 1'b1);
    @(negedge clk);
    check_bit("t1_wb_e4", wb_valid, 1'b0);
    check_bit("t1_busy_e4", busy, 1'b0);
    read_check("t1_hi", 8'd128, 16'hFFA1);
    read_check("t1_lo", 8'd0, 16'h0069);
    @(negedge clk);
    check_bit("t1_rvalid_pulse", host_rvalid, 1'b0);

    // Test 2: zeta=0 -> t=0, both outputs equal f.
    host_write(8'd4, 16'h0123);
    host_write(8'd5, 16'h0456);
    issue(8'd4, 8'd5, 16'd0);
    repeat (4) @(negedge clk);
    read_check("t2_lo", 8'd4, 16'h0123);
    read_check("t2_hi", 8'd5, 16'h0123);

    // Test 3: 16-bit wrap on f+t.
    host_write(8'd2, 16'h7FFF);
    host_write(8'd3, 16'h0001);
    issue(8'd2, 8'd3, 16'd2285);
    repeat (4) @(negedge clk);
    read_check("t3_lo", 8'd2, 16'h8000);
    read_check("t3_hi", 8'd3, 16'h7FFE);

    // Test 4: first NTT layer, 128 back-to-back ops.
    for (int j = 0; j < 256; j++) begin
      model[j] = 16'($urandom_range(0, 3328));
      host_write(8'(j), model[j]);
    end
    wb_count = 0;
    wb_first = -1;
    for (int c = 0; c < 132; c++) begin
      if (c < 128) begin
        bf_valid   = 1'b1;
        bf_addr_lo = 8'(c);
        bf_addr_hi = 8'(c + 128);
        bf_zeta    = 16'd2285;
      end else begin
        bf_valid = 1'b0;
      end
      @(negedge clk);
      if (wb_valid) begin
        wb_count++;
        if (wb_first < 0) wb_first = c;
      end
      if (c == 130) check_bit("t4_busy_last", busy, 1'b1);
      if (c == 131) check_bit("t4_busy_idle", busy, 1'b0);
    end
    bf_valid = 1'b0;
    check_int("t4_wb_count", wb_count, 128);
    check_int("t4_wb_first", wb_first, 3);
    for (int j = 0; j < 128; j++) begin
      tq = fqmul(model[j + 128], 16'd2285);
      expv[j]       = model[j] + tq;
      expv[j + 128] = model[j] - tq;
    end
    for (int j = 0; j < 256; j++) begin
      read_check($sformatf("t4_ram_%0d", j), 8'(j), expv[j]);
    end

    // Test 5: reset two edges after issue aborts the op.
    host_write(8'd10, 16'h0050);
    host_write(8'd20, 16'h0030);
    issue(8'd10, 8'd20, 16'd2285);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_bit("t5_wb_after_rst", wb_valid, 1'b0);
    check_bit("t5_busy_after_rst", busy, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_bit("t5_wb_later", wb_valid, 1'b0);
    read_check("t5_lo", 8'd10, 16'h0050);
    read_check("t5_hi", 8'd20, 16'h0030);

    // Test 6: host gating.
    host_write(8'd40, 16'h1111);
    host_write(8'd30, 16'h0007);
    host_write(8'd31, 16'h0009);
    issue(8'd30, 8'd31, 16'd0);
    host_write(8'd40, 16'h2222);
    host_read(8'd40, rd, rv);
    check_bit("t6_read_busy_dropped", rv, 1'b0);
    repeat (3) @(negedge clk);
    read_check("t6_write_busy_dropped", 8'd40, 16'h1111);
    host_we = 1'b1; host_re = 1'b1; host_addr = 8'd40; host_wdata = 16'h3333;
    @(negedge clk);
    host_we = 1'b0; host_re = 1'b0;
    check_bit("t6_we_re_no_rvalid", host_rvalid, 1'b0);
    read_check("t6_we_wins", 8'd40, 16'h3333);
    bf_valid = 1'b1; bf_addr_lo = 8'd50; bf_addr_hi = 8'd51; bf_zeta = 16'd0;
    host_we = 1'b1; host_addr = 8'd40; host_wdata = 16'h4444;
    @(negedge clk);
    bf_valid = 1'b0; host_we = 1'b0;
    repeat (4) @(negedge clk);
    read_check("t6_write_bf_dropped", 8'd40, 16'h3333);
    read_check("t6_op30_lo", 8'd30, 16'h0007);
    read_check("t6_op31_hi", 8'd31, 16'h0007);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
